// File: rtl/de10_periph_defs_pkg.sv
// Shared definitions for the DE10 peripheral blocks: bus tag placement and
// GPIO register indices (addr[5:2]).
package de10_periph_defs;

  localparam int unsigned TAG_LSB = 22;
  localparam int unsigned TAG_W   = 10;

  localparam logic [3:0] REG_LED      = 4'd0;
  localparam logic [3:0] REG_OUT_LO   = 4'd1;
  localparam logic [3:0] REG_OUT_HI   = 4'd2;
  localparam logic [3:0] REG_DIR_LO   = 4'd3;
  localparam logic [3:0] REG_DIR_HI   = 4'd4;
  localparam logic [3:0] REG_IN_LO    = 4'd5;
  localparam logic [3:0] REG_IN_HI    = 4'd6;
  localparam logic [3:0] REG_STAT_LO  = 4'd7;
  localparam logic [3:0] REG_STAT_HI  = 4'd8;
  localparam logic [3:0] REG_IEN_LO   = 4'd9;
  localparam logic [3:0] REG_IEN_HI   = 4'd10;
  localparam logic [3:0] REG_OUT_SET  = 4'd12;
  localparam logic [3:0] REG_OUT_CLR  = 4'd13;
  localparam logic [3:0] REG_OUT_TGL  = 4'd14;
  localparam logic [3:0] REG_HALF_SEL = 4'd15;

  // Places a 32-bit bus word into the LO or HI half of a 64-bit pin vector.
  function automatic logic [63:0] half_place(input logic hi, input logic [31:0] d);
    return hi ? {d, 32'h0} : {32'h0, d};
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Per-pin two-flop synchroniser plus an edge flop; lvl is the second stage,
// rise is a one-cycle pulse on a synchronised 0->1 transition.
module gpio_sync_edge #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] lvl,
  output logic [W-1:0] rise
);

  logic [W-1:0] s1_q, s2_q, s3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign lvl  = s2_q;
  assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/de10_gpio_periph.sv
// Memory-mapped LED/GPIO block with direction control, edge capture and irq.
// Optional atomic set/clear/toggle aliases at indices 12..15: DE10_GPIO_ATOMIC_EN.
module de10_gpio_periph
  import de10_periph_defs::*;
#(
  parameter logic [9:0]  TAG      = 10'd1,
  parameter int unsigned NUM_GPIO = 36,
  parameter int unsigned LED_W    = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         addr,
  input  logic                wr,
  input  logic                rd,
  input  logic [31:0]         idata,
  output logic [31:0]         odata,
  output logic                rvalid,
  output logic                irq,
  output logic [LED_W-1:0]    LEDR,
  inout  wire  [NUM_GPIO-1:0] GPIO
);

  localparam logic [63:0] GPIO_MASK = (NUM_GPIO >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                       : ((64'd1 << NUM_GPIO) - 64'd1);
  localparam logic [31:0] LED_MASK  = (LED_W >= 32) ? 32'hFFFF_FFFF
                                                    : ((32'd1 << LED_W) - 32'd1);

  // Registers are held 64/32 bits wide; bits outside the configured width are
  // forced to zero so read-back and HI-half handling need no special cases.
  logic [31:0] led_q, led_n;
  logic [63:0] out_q, out_n;
  logic [63:0] dir_q, dir_n;
  logic [63:0] stat_q, stat_n;
  logic [63:0] ien_q, ien_n;
  logic [63:0] clr;
  logic [63:0] in64, rise64;
  logic [31:0] rdata;

  logic [NUM_GPIO-1:0] pin_in, sync_lvl, sync_rise;

  logic       sel, acc_wr, acc_rd;
  logic [3:0] idx;
  logic       unused_addr;

  assign sel    = (addr[TAG_LSB +: TAG_W] == TAG);
  assign idx    = addr[5:2];
  assign acc_wr = wr && sel;
  assign acc_rd = rd && sel;
  assign unused_addr = ^{addr[21:6], addr[1:0]};

`ifdef DE10_GPIO_ATOMIC_EN
  logic        half_q;
  logic [63:0] at_op;
  assign at_op = half_place(half_q, idata);
`endif

  for (genvar i = 0; i < NUM_GPIO; i++) begin : g_pin
    assign GPIO[i] = dir_q[i] ? out_q[i] : 1'bz;
  end
  assign pin_in = GPIO;

  gpio_sync_edge #(.W(NUM_GPIO)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (pin_in),
    .lvl  (sync_lvl),
    .rise (sync_rise)
  );

  assign in64   = 64'(sync_lvl);
  assign rise64 = 64'(sync_rise);

  always_comb begin
    led_n = led_q;
    out_n = out_q;
    dir_n = dir_q;
    ien_n = ien_q;
    clr   = '0;
    if (acc_wr) begin
      case (idx)
        REG_LED:     led_n = idata;
        REG_OUT_LO:  out_n = {out_q[63:32], idata};
        REG_OUT_HI:  out_n = {idata, out_q[31:0]};
        REG_DIR_LO:  dir_n = {dir_q[63:32], idata};
        REG_DIR_HI:  dir_n = {idata, dir_q[31:0]};
        REG_STAT_LO: clr   = half_place(1'b0, idata);
        REG_STAT_HI: clr   = half_place(1'b1, idata);
        REG_IEN_LO:  ien_n = {ien_q[63:32], idata};
        REG_IEN_HI:  ien_n = {idata, ien_q[31:0]};
`ifdef DE10_GPIO_ATOMIC_EN
        REG_OUT_SET: out_n = out_q | at_op;
        REG_OUT_CLR: out_n = out_q & ~at_op;
        REG_OUT_TGL: out_n = out_q ^ at_op;
`endif
        default: ;
      endcase
    end
    // A new edge outranks a same-cycle clear so no event is lost.
    stat_n = (stat_q & ~clr) | rise64;
  end

  always_comb begin
    rdata = '0;
    case (idx)
      REG_LED:     rdata = led_q;
      REG_OUT_LO:  rdata = out_q[31:0];
      REG_OUT_HI:  rdata = out_q[63:32];
      REG_DIR_LO:  rdata = dir_q[31:0];
      REG_DIR_HI:  rdata = dir_q[63:32];
      REG_IN_LO:   rdata = in64[31:0];
      REG_IN_HI:   rdata = in64[63:32];
      REG_STAT_LO: rdata = stat_q[31:0];
      REG_STAT_HI: rdata = stat_q[63:32];
      REG_IEN_LO:  rdata = ien_q[31:0];
      REG_IEN_HI:  rdata = ien_q[63:32];
      default:     rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q  <= '0;
      out_q  <= '0;
      dir_q  <= '0;
      stat_q <= '0;
      ien_q  <= '0;
      irq    <= 1'b0;
      odata  <= '0;
      rvalid <= 1'b0;
    end else begin
      led_q  <= led_n & LED_MASK;
      out_q  <= out_n & GPIO_MASK;
      dir_q  <= dir_n & GPIO_MASK;
      stat_q <= stat_n & GPIO_MASK;
      ien_q  <= ien_n & GPIO_MASK;
      irq    <= |(stat_q & ien_q);
      odata  <= acc_rd ? rdata : '0;
      rvalid <= rd;
    end
  end

`ifdef DE10_GPIO_ATOMIC_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      half_q <= 1'b0;
    end else if (acc_wr && idx == REG_HALF_SEL) begin
      half_q <= idata[0];
    end
  end
`endif

  assign LEDR = led_q[LED_W-1:0];

endmodule

// File: tb/tb_de10_gpio_periph.sv
// Directed, table-driven bench for de10_gpio_periph (TAG=1, 36 pins, 10 LEDs).
module tb_de10_gpio_periph;
  import de10_periph_defs::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        wr, rd;
  logic [31:0] idata;
  logic [31:0] odata;
  logic        rvalid, irq;
  logic [9:0]  ledr;
  wire  [35:0] gpio;

  logic [35:0] tb_en, tb_val;

  int checks = 0;
  int errors = 0;

  for (genvar i = 0; i < 36; i++) begin : g_drv
    assign gpio[i] = tb_en[i] ? tb_val[i] : 1'bz;
  end

  de10_gpio_periph #(.TAG(10'd1), .NUM_GPIO(36), .LED_W(10)) dut (
    .clk    (clk),
    .rst    (rst),
    .addr   (addr),
    .wr     (wr),
    .rd     (rd),
    .idata  (idata),
    .odata  (odata),
    .rvalid (rvalid),
    .irq    (irq),
    .LEDR   (ledr),
    .GPIO   (gpio)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    logic        w;
    logic        r;
    logic [9:0]  tag;
    logic [3:0]  idx;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_addr(input logic [9:0] tag, input logic [3:0] idx);
    return {tag, 16'h0, idx, 2'b00};
  endfunction

  task automatic bus_write(input logic [9:0] tag, input logic [3:0] idx, input logic [31:0] d);
    @(negedge clk);
    addr = mk_addr(tag, idx); idata = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic bus_read(input string name, input logic [9:0] tag, input logic [3:0] idx,
                          input logic [31:0] exp);
    @(negedge clk);
    addr = mk_addr(tag, idx); rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    check({name, "_rvalid"}, {63'h0, rvalid}, 64'h1);
    check(name, {32'h0, odata}, {32'h0, exp});
  endtask

  task automatic add(input logic w, input logic r, input logic [9:0] tag, input logic [3:0] idx,
                     input logic [31:0] data, input logic [31:0] exp);
    vec_t v;
    v.w = w; v.r = r; v.tag = tag; v.idx = idx; v.data = data; v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; idata = '0;
    tb_en = '1; tb_val = '0;

    for (int unsigned i = 0; i <= 10; i++) add(1'b0, 1'b1, 10'd1, 4'(i), 32'h0, 32'h0);
    add(1'b1, 1'b0, 10'd1, REG_OUT_HI, 32'hFFFF_FFFF, 32'h0);
    add(1'b0, 1'b1, 10'd1, REG_OUT_HI, 32'h0, 32'h0000_000F);
    add(1'b1, 1'b0, 10'd1, REG_IN_LO,  32'h0000_1234, 32'h0);
    add(1'b0, 1'b1, 10'd1, REG_IN_LO,  32'h0, 32'h0);
    add(1'b1, 1'b0, 10'd1, 4'd11, 32'hDEAD_BEEF, 32'h0);
    add(1'b0, 1'b1, 10'd1, 4'd11, 32'h0, 32'h0);
    add(1'b1, 1'b1, 10'd1, REG_IEN_LO, 32'h0000_0055, 32'h0);
    add(1'b0, 1'b1, 10'd1, REG_IEN_LO, 32'h0, 32'h0000_0055);
    add(1'b1, 1'b0, 10'd1, REG_IEN_LO, 32'h0, 32'h0);
    add(1'b1, 1'b0, 10'd1, REG_IEN_HI, 32'hFFFF_FFFF, 32'h0);
    add(1'b0, 1'b1, 10'd1, REG_IEN_HI, 32'h0, 32'h0000_000F);
    add(1'b1, 1'b0, 10'd1, REG_IEN_HI, 32'h0, 32'h0);
    add(1'b0, 1'b1, 10'd2, REG_OUT_HI, 32'h0, 32'h0);

    repeat (3) @(negedge clk);
    check("reset_rvalid", {63'h0, rvalid}, 64'h0);
    check("reset_odata", {32'h0, odata}, 64'h0);
    check("reset_irq", {63'h0, irq}, 64'h0);
    check("reset_ledr", {54'h0, ledr}, 64'h0);
    rst = 1'b0;

    // Register map sweep
    foreach (vecs[k]) begin
      @(negedge clk);
      addr = mk_addr(vecs[k].tag, vecs[k].idx); idata = vecs[k].data;
      wr = vecs[k].w; rd = vecs[k].r;
      @(negedge clk);
      wr = 1'b0; rd = 1'b0;
      check($sformatf("vec%0d_rvalid", k), {63'h0, rvalid}, {63'h0, vecs[k].r});
      if (vecs[k].r) check($sformatf("vec%0d_odata", k), {32'h0, odata}, {32'h0, vecs[k].exp});
    end
    check("sweep_irq", {63'h0, irq}, 64'h0);

    // Output drive and IN read-back
    tb_en[7:0] = '0;
    bus_write(10'd1, REG_DIR_LO, 32'h0000_00FF);
    bus_write(10'd1, REG_OUT_LO, 32'h0000_00A5);
    check("pins_out", {56'h0, gpio[7:0]}, 64'hA5);
    repeat (2) @(negedge clk);
    bus_read("in_lo_out", 10'd1, REG_IN_LO, 32'h0000_00A5);
    bus_read("dir_lo", 10'd1, REG_DIR_LO, 32'h0000_00FF);

    // Edge capture and irq
    bus_write(10'd1, REG_DIR_LO, 32'h0);
    tb_en = '1; tb_val = '0;
    repeat (4) @(negedge clk);
    bus_write(10'd1, REG_STAT_LO, 32'hFFFF_FFFF);
    bus_write(10'd1, REG_IEN_LO, 32'h0000_0001);
    @(negedge clk);
    bus_read("stat_cleared", 10'd1, REG_STAT_LO, 32'h0);
    check("irq_idle", {63'h0, irq}, 64'h0);
    tb_val[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("irq_p2", {63'h0, irq}, 64'h0);
    @(negedge clk);
    check("irq_p3", {63'h0, irq}, 64'h0);
    @(negedge clk);
    check("irq_p4", {63'h0, irq}, 64'h1);
    bus_read("stat_set", 10'd1, REG_STAT_LO, 32'h0000_0001);
    bus_write(10'd1, REG_STAT_LO, 32'h0000_0001);
    check("irq_lag", {63'h0, irq}, 64'h1);
    @(negedge clk);
    check("irq_cleared", {63'h0, irq}, 64'h0);
    bus_read("stat_w1c", 10'd1, REG_STAT_LO, 32'h0);

    // Edge and W1C in the same cycle
    tb_val[0] = 1'b0;
    repeat (4) @(negedge clk);
    bus_read("stat_fall", 10'd1, REG_STAT_LO, 32'h0);
    tb_val[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    addr = mk_addr(10'd1, REG_STAT_LO); idata = 32'h1; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    bus_read("stat_set_wins", 10'd1, REG_STAT_LO, 32'h0000_0001);
    bus_write(10'd1, REG_STAT_LO, 32'h0000_0001);
    bus_read("stat_w1c2", 10'd1, REG_STAT_LO, 32'h0);

    // Tag filtering
    bus_write(10'd2, REG_LED, 32'hFFFF_FFFF);
    check("ledr_wrong_tag", {54'h0, ledr}, 64'h0);
    bus_read("led_wrong_tag", 10'd2, REG_LED, 32'h0);
    bus_write(10'd1, REG_LED, 32'hFFFF_FFFF);
    check("ledr_tag1", {54'h0, ledr}, 64'h3FF);
    bus_read("led_tag1", 10'd1, REG_LED, 32'h0000_03FF);

    // Atomic aliases
    bus_write(10'd1, REG_OUT_LO, 32'h0000_00F0);
`ifdef DE10_GPIO_ATOMIC_EN
    bus_write(10'd1, REG_OUT_SET, 32'h0000_000F);
    bus_read("out_set", 10'd1, REG_OUT_LO, 32'h0000_00FF);
    bus_write(10'd1, REG_OUT_CLR, 32'h0000_0081);
    bus_read("out_clr", 10'd1, REG_OUT_LO, 32'h0000_007E);
    bus_write(10'd1, REG_OUT_TGL, 32'h0000_00FF);
    bus_read("out_tgl", 10'd1, REG_OUT_LO, 32'h0000_0081);
    bus_read("alias_rd0", 10'd1, REG_OUT_SET, 32'h0);
    bus_write(10'd1, REG_HALF_SEL, 32'h0000_0001);
    bus_write(10'd1, REG_OUT_CLR, 32'h0000_0001);
    bus_read("out_hi_clr", 10'd1, REG_OUT_HI, 32'h0000_000E);
    bus_read("out_lo_kept", 10'd1, REG_OUT_LO, 32'h0000_0081);
`else
    bus_write(10'd1, REG_OUT_SET, 32'h0000_000F);
    bus_write(10'd1, REG_OUT_CLR, 32'h0000_00F0);
    bus_write(10'd1, REG_OUT_TGL, 32'h0000_00FF);
    bus_write(10'd1, REG_HALF_SEL, 32'h0000_0001);
    bus_read("out_lo_noalias", 10'd1, REG_OUT_LO, 32'h0000_00F0);
    bus_read("out_hi_noalias", 10'd1, REG_OUT_HI, 32'h0000_000F);
    bus_read("idx12_rd0", 10'd1, REG_OUT_SET, 32'h0);
`endif

    // Reset during a read
    @(negedge clk);
    addr = mk_addr(10'd1, REG_LED); rd = 1'b1; rst = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    check("rst_rvalid", {63'h0, rvalid}, 64'h0);
    check("rst_odata", {32'h0, odata}, 64'h0);
    rst = 1'b0;
    check("rst_ledr", {54'h0, ledr}, 64'h0);
    bus_read("rst_led", 10'd1, REG_LED, 32'h0);
    bus_read("rst_out_hi", 10'd1, REG_OUT_HI, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
